// File: rtl/blackjack_round_controller_if.sv
// Bundles the controller's button, deck RAM, adder and status signals.
// master = round controller side, slave = board/RAM/adder side.
interface blackjack_round_controller_if;
    logic       Start;
    logic       Hit;
    logic       Stay;
    logic [5:0] o_Memory_Adress;
    logic [3:0] i_Card;
    logic       o_Sum;
    logic [3:0] o_Card_Value;
    logic [4:0] o_Initial_Hand;
    logic       o_Ace;
    logic [4:0] i_Final_Hand;
    logic       i_Ace;
    logic       i_Add_Done;
    logic [4:0] Player_Hand;
    logic [4:0] Dealer_Hand;
    logic       Busy;
    logic       Player_Turn;
    logic       Win;
    logic       Lose;
    logic       Tie;
    logic       Error;

    modport master (
        input  Start, Hit, Stay, i_Card, i_Final_Hand, i_Ace, i_Add_Done,
        output o_Memory_Adress, o_Sum, o_Card_Value, o_Initial_Hand, o_Ace,
               Player_Hand, Dealer_Hand, Busy, Player_Turn, Win, Lose, Tie, Error
    );

    modport slave (
        output Start, Hit, Stay, i_Card, i_Final_Hand, i_Ace, i_Add_Done,
        input  o_Memory_Adress, o_Sum, o_Card_Value, o_Initial_Hand, o_Ace,
               Player_Hand, Dealer_Hand, Busy, Player_Turn, Win, Lose, Tie, Error
    );
endinterface

// File: rtl/blackjack_round_controller.sv
// Sequences one blackjack round: deck fetch, one adder request per card, deal/player/dealer turns, outcome.
// Latency: 2 cycles per card fetch (+2 per skipped card), then adder round trip; all outputs registered.
// Backpressure: waits on i_Add_Done up to ADD_TIMEOUT cycles after o_Sum, then latches Error until Reset.
module blackjack_round_controller #(
    parameter int DECK_SIZE    = 52,
    parameter int DEALER_STAND = 17,
    parameter int ADD_TIMEOUT  = 8
) (
    input logic                          Clock,
    input logic                          Reset,
    blackjack_round_controller_if.master bus
);
    localparam int         TW       = $clog2(ADD_TIMEOUT + 1);
    localparam logic [5:0] PTR_LAST = 6'(DECK_SIZE - 1);
    localparam logic [4:0] STAND    = 5'(DEALER_STAND);
    localparam logic [TW-1:0] TO_LAST = TW'(ADD_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, LOAD, ADD, WAIT_ADD, UPDATE,
        PLAYER_TURN, DEALER_TURN, RESULT, ERROR
    } state_t;

    state_t        state;
    logic [5:0]    ptr;
    logic [1:0]    deal_cnt;
    logic          dealing;
    logic          target_dealer;
    logic [3:0]    card;
    logic [TW-1:0] timer;
    logic [4:0]    player_hand, dealer_hand;
    logic          player_ace, dealer_ace;
    logic          sum_q, init_ace;
    logic [4:0]    init_hand;
    logic          busy, player_turn, win, lose, tie, error;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= IDLE;
            ptr           <= '0;
            deal_cnt      <= '0;
            dealing       <= 1'b0;
            target_dealer <= 1'b0;
            card          <= '0;
            timer         <= '0;
            player_hand   <= '0;
            dealer_hand   <= '0;
            player_ace    <= 1'b0;
            dealer_ace    <= 1'b0;
            sum_q         <= 1'b0;
            init_hand     <= '0;
            init_ace      <= 1'b0;
            busy          <= 1'b0;
            player_turn   <= 1'b0;
            win           <= 1'b0;
            lose          <= 1'b0;
            tie           <= 1'b0;
            error         <= 1'b0;
        end else begin
            case (state)
                IDLE, RESULT: begin
                    if (bus.Start) begin
                        player_hand   <= '0;
                        dealer_hand   <= '0;
                        player_ace    <= 1'b0;
                        dealer_ace    <= 1'b0;
                        win           <= 1'b0;
                        lose          <= 1'b0;
                        tie           <= 1'b0;
                        busy          <= 1'b1;
                        deal_cnt      <= '0;
                        dealing       <= 1'b1;
                        target_dealer <= 1'b0;
                        state         <= FETCH;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    card <= bus.i_Card;
                    ptr  <= (ptr == PTR_LAST) ? 6'd0 : ptr + 6'd1;
                    if (bus.i_Card == 4'd0 || bus.i_Card > 4'd13) begin
                        state <= FETCH;
                    end else begin
                        // Request fields are registered here so they coincide with o_Sum in ADD.
                        sum_q     <= 1'b1;
                        init_hand <= target_dealer ? dealer_hand : player_hand;
                        init_ace  <= target_dealer ? dealer_ace : player_ace;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    sum_q <= 1'b0;
                    timer <= TW'(1);
                    state <= WAIT_ADD;
                end
                WAIT_ADD: begin
                    if (bus.i_Add_Done) begin
                        if (target_dealer) begin
                            dealer_hand <= bus.i_Final_Hand;
                            dealer_ace  <= bus.i_Ace;
                        end else begin
                            player_hand <= bus.i_Final_Hand;
                            player_ace  <= bus.i_Ace;
                        end
                        state <= UPDATE;
                    end else if (timer == TO_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERROR;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                UPDATE: begin
                    if (dealing && deal_cnt != 2'd3) begin
                        deal_cnt      <= deal_cnt + 2'd1;
                        target_dealer <= ~target_dealer;
                        state         <= FETCH;
                    end else if (dealing || !target_dealer) begin
                        dealing       <= 1'b0;
                        target_dealer <= 1'b0;
                        if (player_hand > 5'd21) begin
                            lose  <= 1'b1;
                            busy  <= 1'b0;
                            state <= RESULT;
                        end else begin
                            player_turn <= 1'b1;
                            state       <= PLAYER_TURN;
                        end
                    end else begin
                        state <= DEALER_TURN;
                    end
                end
                PLAYER_TURN: begin
                    // Stay is checked first so a simultaneous Hit is dropped.
                    if (bus.Stay) begin
                        player_turn <= 1'b0;
                        state       <= DEALER_TURN;
                    end else if (bus.Hit) begin
                        player_turn   <= 1'b0;
                        target_dealer <= 1'b0;
                        state         <= FETCH;
                    end
                end
                DEALER_TURN: begin
                    if (dealer_hand < STAND) begin
                        target_dealer <= 1'b1;
                        state         <= FETCH;
                    end else begin
                        busy  <= 1'b0;
                        state <= RESULT;
                        if (dealer_hand > 5'd21 || player_hand > dealer_hand) win <= 1'b1;
                        else if (player_hand == dealer_hand)                 tie <= 1'b1;
                        else                                                 lose <= 1'b1;
                    end
                end
                ERROR:   state <= ERROR;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_Memory_Adress = ptr;
    assign bus.o_Sum           = sum_q;
    assign bus.o_Card_Value    = card;
    assign bus.o_Initial_Hand  = init_hand;
    assign bus.o_Ace           = init_ace;
    assign bus.Player_Hand     = player_hand;
    assign bus.Dealer_Hand     = dealer_hand;
    assign bus.Busy            = busy;
    assign bus.Player_Turn     = player_turn;
    assign bus.Win             = win;
    assign bus.Lose            = lose;
    assign bus.Tie             = tie;
    assign bus.Error           = error;
endmodule

// File: tb/tb_blackjack_round_controller.sv
// Bench for blackjack_round_controller: deck RAM and adder models, a card-level game model,
// a per-cycle request/outcome checker and directed rounds with literal expectations.
module tb_blackjack_round_controller;
    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    blackjack_round_controller_if bus ();
    blackjack_round_controller #(.DECK_SIZE(52), .DEALER_STAND(17), .ADD_TIMEOUT(8)) dut (
        .Clock(Clock), .Reset(Reset), .bus(bus)
    );

    typedef struct { logic [3:0] card; logic [4:0] hand; logic ace; } req_t;

    int   n_cmp = 0, n_fail = 0;
    logic [3:0] mem [0:63];
    req_t exp_q[$];
    req_t cur_req;
    int   acts[$];                 // 0 = Stay, 1 = Hit, 2 = Hit+Stay together
    int   m_p, m_h[2], exp_wlt, cur_ptr, deal_p, deal_d, sum_count;
    bit   m_a[2];
    bit   outstanding;
    logic add_en;
    int   add_cnt;
    logic [5:0] add_res;

    function automatic void check(string name, longint act, longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endfunction

    // Blackjack adder behaviour: faces count 10, ace is 11 when it fits, soft ace demotes on bust.
    function automatic logic [5:0] add_card(input logic [3:0] c, input logic [4:0] h, input logic a);
        int t;
        logic sa;
        t = int'(h);
        sa = a;
        if (c == 4'd1 && t + 11 <= 21) begin
            t += 11;
            sa = 1'b1;
        end else begin
            t += (c >= 4'd10) ? 10 : int'(c);
        end
        if (t > 21 && sa) begin
            t -= 10;
            sa = 1'b0;
        end
        return {sa, 5'(t)};
    endfunction

    always @(posedge Clock) bus.i_Card <= mem[bus.o_Memory_Adress];

    always @(posedge Clock) begin
        bus.i_Add_Done <= 1'b0;
        if (Reset) begin
            add_cnt <= 0;
        end else if (bus.o_Sum && add_en) begin
            add_res <= add_card(bus.o_Card_Value, bus.o_Initial_Hand, bus.o_Ace);
            add_cnt <= 1;
        end else if (add_cnt == 1) begin
            bus.i_Add_Done   <= 1'b1;
            bus.i_Final_Hand <= add_res[4:0];
            bus.i_Ace        <= add_res[5];
            add_cnt          <= 0;
        end
    end

    function automatic void m_draw(input int who);
        logic [3:0] c;
        logic [5:0] r;
        req_t q;
        do begin
            c = mem[m_p];
            m_p = (m_p == 51) ? 0 : m_p + 1;
        end while (c == 4'd0 || c > 4'd13);
        q.card = c;
        q.hand = 5'(m_h[who]);
        q.ace  = m_a[who];
        exp_q.push_back(q);
        r = add_card(c, 5'(m_h[who]), m_a[who]);
        m_h[who] = int'(r[4:0]);
        m_a[who] = r[5];
    endfunction

    // Plays the whole round at card level: expected add requests, final hands, outcome, pointer.
    function automatic void build_model(input int start_ptr);
        int ai, a;
        bit done;
        m_p = start_ptr;
        m_h[0] = 0; m_h[1] = 0; m_a[0] = 0; m_a[1] = 0;
        exp_q.delete();
        sum_count = 0;
        for (int i = 0; i < 4; i++) m_draw(i % 2);
        done = 0;
        exp_wlt = 0;
        if (m_h[0] > 21) begin exp_wlt = 2; done = 1; end
        ai = 0;
        while (!done) begin
            a = (ai < acts.size()) ? acts[ai] : 0;
            ai++;
            if (a == 1) begin
                m_draw(0);
                if (m_h[0] > 21) begin exp_wlt = 2; done = 1; end
            end else begin
                while (m_h[1] < 17) m_draw(1);
                if (m_h[1] > 21 || m_h[0] > m_h[1]) exp_wlt = 4;
                else if (m_h[0] == m_h[1])          exp_wlt = 1;
                else                                exp_wlt = 2;
                done = 1;
            end
        end
    endfunction

    always @(negedge Clock) begin
        if (Reset) begin
            outstanding = 0;
        end else begin
            if (bus.o_Sum) begin
                sum_count++;
                check("sum_overlap", outstanding, 0);
                outstanding = 1;
                if (exp_q.size() == 0) begin
                    check("sum_unexpected", bus.o_Sum, 0);
                end else begin
                    cur_req = exp_q.pop_front();
                    check("sum_card", bus.o_Card_Value, cur_req.card);
                    check("sum_hand", bus.o_Initial_Hand, cur_req.hand);
                    check("sum_ace", bus.o_Ace, cur_req.ace);
                end
            end
            if (bus.i_Add_Done || bus.Error) outstanding = 0;
            check("outcome_flags", ($countones({bus.Win, bus.Lose, bus.Tie}) > 1) ||
                  (bus.Busy && (bus.Win || bus.Lose || bus.Tie)), 0);
        end
    end

    function automatic longint all_outs();
        return longint'({bus.o_Memory_Adress, bus.o_Sum, bus.o_Card_Value, bus.o_Initial_Hand,
                         bus.o_Ace, bus.Player_Hand, bus.Dealer_Hand, bus.Busy, bus.Player_Turn,
                         bus.Win, bus.Lose, bus.Tie, bus.Error});
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        check("reset_outputs", all_outs(), 0);
        Reset = 1'b0;
        cur_ptr = 0;
    endtask

    task automatic clear_deck();
        for (int i = 0; i < 64; i++) mem[i] = 4'd0;
    endtask

    task automatic run_round(input bit restart);
        int ai, a, b;
        bit seen, first;
        ai = 0; seen = 0; first = 1;
        build_model(cur_ptr);
        @(negedge Clock);
        bus.Start = 1'b1;
        for (b = 0; b < 3000; b++) begin
            @(negedge Clock);
            bus.Start = restart && (b == 4);
            if (bus.Busy) seen = 1;
            if (bus.Player_Turn) begin
                if (first) begin
                    deal_p = int'(bus.Player_Hand);
                    deal_d = int'(bus.Dealer_Hand);
                    first = 0;
                end
                a = (ai < acts.size()) ? acts[ai] : 0;
                ai++;
                bus.Hit  = (a != 0);
                bus.Stay = (a != 1);
                @(negedge Clock);
                bus.Hit  = 1'b0;
                bus.Stay = 1'b0;
            end
            if ((seen && !bus.Busy) || bus.Error) break;
        end
        bus.Start = 1'b0;
        check("round_done", seen && !bus.Busy && !bus.Error, 1);
        check("player_hand", bus.Player_Hand, m_h[0]);
        check("dealer_hand", bus.Dealer_Hand, m_h[1]);
        check("outcome", {bus.Win, bus.Lose, bus.Tie}, exp_wlt);
        check("pointer", bus.o_Memory_Adress, m_p);
        check("reqs_left", exp_q.size(), 0);
        cur_ptr = m_p;
    endtask

    initial begin
        int k;
        bus.Start = 1'b0; bus.Hit = 1'b0; bus.Stay = 1'b0;
        add_en = 1'b1;
        clear_deck();
        do_reset();

        // Round 1: stand on 15, dealer hits 16 to 20; a Start mid-round must be ignored.
        clear_deck();
        mem[0] = 10; mem[1] = 7; mem[2] = 5; mem[3] = 9; mem[4] = 4;
        acts.delete(); acts.push_back(0);
        run_round(1'b1);
        check("t1_deal_player", deal_p, 15);
        check("t1_deal_dealer", deal_d, 16);
        check("t1_dealer_final", bus.Dealer_Hand, 20);
        check("t1_lose", bus.Lose, 1);
        check("t1_pointer", bus.o_Memory_Adress, 5);
        check("t1_sums", sum_count, 5);

        // Round 2: hit on 20 busts to 30, dealer never draws.
        do_reset();
        clear_deck();
        mem[0] = 10; mem[1] = 7; mem[2] = 13; mem[3] = 9; mem[4] = 13;
        acts.delete(); acts.push_back(1);
        run_round(1'b0);
        check("t2_deal_player", deal_p, 20);
        check("t2_player_final", bus.Player_Hand, 30);
        check("t2_lose", bus.Lose, 1);
        check("t2_pointer", bus.o_Memory_Adress, 5);
        check("t2_sums", sum_count, 5);

        // Round 3: soft 21 against 18.
        do_reset();
        clear_deck();
        mem[0] = 1; mem[1] = 10; mem[2] = 13; mem[3] = 8;
        acts.delete(); acts.push_back(0);
        run_round(1'b0);
        check("t3_player", bus.Player_Hand, 21);
        check("t3_dealer", bus.Dealer_Hand, 18);
        check("t3_win", bus.Win, 1);

        // Round 4: two bad cards skipped, 18 vs 18.
        do_reset();
        clear_deck();
        mem[0] = 0; mem[1] = 15; mem[2] = 9; mem[3] = 9; mem[4] = 9; mem[5] = 9;
        acts.delete(); acts.push_back(0);
        run_round(1'b0);
        check("t4_player", bus.Player_Hand, 18);
        check("t4_dealer", bus.Dealer_Hand, 18);
        check("t4_tie", bus.Tie, 1);
        check("t4_sums", sum_count, 4);

        // Adder timeout.
        do_reset();
        clear_deck();
        mem[0] = 10; mem[1] = 7; mem[2] = 5; mem[3] = 9;
        add_en = 1'b0;
        build_model(0);
        @(negedge Clock); bus.Start = 1'b1;
        @(negedge Clock); bus.Start = 1'b0;
        for (k = 0; k < 50 && !bus.o_Sum; k++) @(negedge Clock);
        check("to_sum_seen", bus.o_Sum, 1);
        for (k = 1; k <= 20; k++) begin
            @(negedge Clock);
            if (bus.Error) break;
        end
        check("to_cycles", k, 8);
        check("to_busy", bus.Busy, 0);
        bus.Start = 1'b1;
        @(negedge Clock); bus.Start = 1'b0;
        @(negedge Clock); @(negedge Clock);
        check("to_start_ignored", {bus.Busy, bus.Error}, 1);
        do_reset();
        add_en = 1'b1;

        // Reset while waiting on the adder.
        clear_deck();
        mem[0] = 10; mem[1] = 7; mem[2] = 5; mem[3] = 9;
        build_model(0);
        @(negedge Clock); bus.Start = 1'b1;
        @(negedge Clock); bus.Start = 1'b0;
        for (k = 0; k < 50 && !bus.o_Sum; k++) @(negedge Clock);
        check("rst_sum_seen", bus.o_Sum, 1);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("rst_mid_outputs", all_outs(), 0);
        Reset = 1'b0;
        cur_ptr = 0;

        // Pointer wraps through DECK_SIZE-1; Hit with Stay acts as Stay; next round restarts at 0.
        clear_deck();
        mem[0] = 10; mem[1] = 6; mem[2] = 7; mem[3] = 5; mem[50] = 5; mem[51] = 3;
        acts.delete(); acts.push_back(2);
        run_round(1'b0);
        check("wrap_player", bus.Player_Hand, 17);
        check("wrap_dealer", bus.Dealer_Hand, 19);
        check("wrap_pointer", bus.o_Memory_Adress, 0);
        acts.delete(); acts.push_back(0);
        run_round(1'b0);
        check("wrap2_player", bus.Player_Hand, 17);
        check("wrap2_lose", bus.Lose, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
